// File: rtl/mbist_pkg.sv
// Shared types for the March C- BIST controller: FSM states, op encoding and
// the per-element March table (direction, op count, op list).
package mbist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam int NUM_ELEMS = 6;

   typedef logic [2:0] elem_idx_t;

   // wr: 1 = write, 0 = read; val: data bit replicated across the word
   typedef struct packed {
      logic wr;
      logic val;
   } op_t;

   localparam op_t OP_R0 = '{wr: 1'b0, val: 1'b0};
   localparam op_t OP_R1 = '{wr: 1'b0, val: 1'b1};
   localparam op_t OP_W0 = '{wr: 1'b1, val: 1'b0};
   localparam op_t OP_W1 = '{wr: 1'b1, val: 1'b1};

   // ops[0] is issued first; ops[1] only when nops == 2
   typedef struct packed {
      logic       down;
      logic [1:0] nops;
      op_t  [1:0] ops;
   } march_elem_t;

   localparam march_elem_t MARCH_TABLE [NUM_ELEMS] = '{
      '{down: 1'b0, nops: 2'd1, ops: {OP_W0, OP_W0}},
      '{down: 1'b0, nops: 2'd2, ops: {OP_W1, OP_R0}},
      '{down: 1'b0, nops: 2'd2, ops: {OP_W0, OP_R1}},
      '{down: 1'b1, nops: 2'd2, ops: {OP_W1, OP_R0}},
      '{down: 1'b1, nops: 2'd2, ops: {OP_W0, OP_R1}},
      '{down: 1'b0, nops: 2'd1, ops: {OP_R0, OP_R0}}
   };

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Memory-side bus between the BIST controller (master) and fault_mem (slave).
interface mbist_march_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  mem_write_read;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_write_read,
      output mem_address,
      output mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_write_read,
      input  mem_address,
      input  mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mbist_rd_cmp.sv
// Read-compare back end: 2-stage expected-data pipeline matching the memory's
// read latency, sticky fail flag, saturating counter, optional MBIST_FAIL_LOG_EN log.
module mbist_rd_cmp
   import mbist_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int FAIL_CNT_WIDTH = 8
`ifdef MBIST_FAIL_LOG_EN
   ,
   parameter int ADDR_WIDTH     = 4
`endif
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr_i,
   input  logic                      push_i,
   input  logic [DATA_WIDTH-1:0]     exp_i,
   input  logic [DATA_WIDTH-1:0]     rdata_i,
`ifdef MBIST_FAIL_LOG_EN
   input  logic [ADDR_WIDTH-1:0]     addr_i,
   input  elem_idx_t                 elem_i,
   output logic [ADDR_WIDTH-1:0]     fail_addr_o,
   output elem_idx_t                 fail_elem_o,
   output logic [DATA_WIDTH-1:0]     fail_exp_o,
   output logic [DATA_WIDTH-1:0]     fail_act_o,
`endif
   output logic                      fail_o,
   output logic [FAIL_CNT_WIDTH-1:0] fail_count_o
);
   localparam int STAGES = 2;

   logic                  vld_q [STAGES];
   logic [DATA_WIDTH-1:0] exp_q [STAGES];
   logic                  fail_q;
   logic [FAIL_CNT_WIDTH-1:0] cnt_q;
   logic                  miscmp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            vld_q[i] <= 1'b0;
            exp_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= push_i;
         exp_q[0] <= exp_i;
         for (int i = 1; i < STAGES; i++) begin
            vld_q[i] <= vld_q[i-1];
            exp_q[i] <= exp_q[i-1];
         end
      end
   end

   assign miscmp = vld_q[STAGES-1] && (rdata_i != exp_q[STAGES-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_q <= 1'b0;
         cnt_q  <= '0;
      end else if (clr_i) begin
         fail_q <= 1'b0;
         cnt_q  <= '0;
      end else if (miscmp) begin
         fail_q <= 1'b1;
         if (cnt_q != '1) cnt_q <= cnt_q + FAIL_CNT_WIDTH'(1);
      end
   end

   assign fail_o       = fail_q;
   assign fail_count_o = cnt_q;

`ifdef MBIST_FAIL_LOG_EN
   logic [ADDR_WIDTH-1:0] addr_q [STAGES];
   elem_idx_t             elem_q [STAGES];
   logic [ADDR_WIDTH-1:0] log_addr_q;
   elem_idx_t             log_elem_q;
   logic [DATA_WIDTH-1:0] log_exp_q;
   logic [DATA_WIDTH-1:0] log_act_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            addr_q[i] <= '0;
            elem_q[i] <= '0;
         end
      end else begin
         addr_q[0] <= addr_i;
         elem_q[0] <= elem_i;
         for (int i = 1; i < STAGES; i++) begin
            addr_q[i] <= addr_q[i-1];
            elem_q[i] <= elem_q[i-1];
         end
      end
   end

   // fail_q still low means this is the first miscompare since start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         log_addr_q <= '0;
         log_elem_q <= '0;
         log_exp_q  <= '0;
         log_act_q  <= '0;
      end else if (clr_i) begin
         log_addr_q <= '0;
         log_elem_q <= '0;
         log_exp_q  <= '0;
         log_act_q  <= '0;
      end else if (miscmp && !fail_q) begin
         log_addr_q <= addr_q[STAGES-1];
         log_elem_q <= elem_q[STAGES-1];
         log_exp_q  <= exp_q[STAGES-1];
         log_act_q  <= rdata_i;
      end
   end

   assign fail_addr_o = log_addr_q;
   assign fail_elem_o = log_elem_q;
   assign fail_exp_o  = log_exp_q;
   assign fail_act_o  = log_act_q;
`endif

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller: FSM plus element/address/op cursor driving fault_mem.
// Optional first-fail log ports are enabled with MBIST_FAIL_LOG_EN.
module mbist_march_ctrl
   import mbist_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int CAPACITY       = 15,
   parameter int FAIL_CNT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   mbist_march_ctrl_if.master        mem,
   output logic                      busy,
   output logic                      done,
   output logic                      fail,
   output logic [FAIL_CNT_WIDTH-1:0] fail_count
`ifdef MBIST_FAIL_LOG_EN
   ,
   output logic [ADDR_WIDTH-1:0]     fail_addr,
   output elem_idx_t                 fail_elem,
   output logic [DATA_WIDTH-1:0]     fail_exp,
   output logic [DATA_WIDTH-1:0]     fail_act
`endif
);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = ADDR_WIDTH'(CAPACITY);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam elem_idx_t             LAST_ELEM = elem_idx_t'(NUM_ELEMS - 1);

   state_t                state_q;
   elem_idx_t             ptr_elem_q;
   logic [ADDR_WIDTH-1:0] ptr_addr_q;
   logic                  ptr_opi_q;
   logic                  wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  iss_rd_q;
   logic [DATA_WIDTH-1:0] iss_exp_q;
   logic                  last_q;
   logic                  drain_q;
   logic                  busy_q;
   logic                  done_q;

   march_elem_t           ptr_ent;
   op_t                   ptr_op;
   logic                  ptr_ops_end;
   logic                  ptr_sweep_end;
   logic                  ptr_last;
   elem_idx_t             ptr_elem_d;
   logic [ADDR_WIDTH-1:0] ptr_addr_d;
   logic                  ptr_opi_d;
   logic                  nxt_val;
   logic                  start_acc;
   logic                  issue_en;

   // ptr_* is the op to issue at the next edge; *_d is the op after it
   always_comb begin
      ptr_ent       = MARCH_TABLE[ptr_elem_q];
      ptr_op        = ptr_ent.ops[ptr_opi_q];
      ptr_ops_end   = (ptr_ent.nops == 2'd1) || ptr_opi_q;
      ptr_sweep_end = ptr_ent.down ? (ptr_addr_q == '0) : (ptr_addr_q == ADDR_MAX);
      ptr_last      = ptr_ops_end && ptr_sweep_end && (ptr_elem_q == LAST_ELEM);
      ptr_elem_d    = ptr_elem_q;
      ptr_addr_d    = ptr_addr_q;
      ptr_opi_d     = 1'b0;
      if (!ptr_ops_end) begin
         ptr_opi_d = 1'b1;
      end else if (!ptr_sweep_end) begin
         ptr_addr_d = ptr_ent.down ? (ptr_addr_q - ADDR_ONE) : (ptr_addr_q + ADDR_ONE);
      end else begin
         ptr_elem_d = (ptr_elem_q == LAST_ELEM) ? '0 : (ptr_elem_q + elem_idx_t'(1));
         ptr_addr_d = MARCH_TABLE[ptr_elem_d].down ? ADDR_MAX : '0;
      end
      nxt_val = MARCH_TABLE[ptr_elem_d].ops[ptr_opi_d].val;
   end

   assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign issue_en  = (state_q == ST_PRIME) || ((state_q == ST_RUN) && !last_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_elem_q <= '0;
         ptr_addr_q <= '0;
         ptr_opi_q  <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         iss_rd_q   <= 1'b0;
         iss_exp_q  <= '0;
         last_q     <= 1'b0;
         drain_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_acc) begin
                  state_q    <= ST_PRIME;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  ptr_elem_q <= '0;
                  ptr_addr_q <= '0;
                  ptr_opi_q  <= 1'b0;
                  last_q     <= 1'b0;
                  wr_q       <= 1'b0;
                  iss_rd_q   <= 1'b0;
                  // memory samples write data one cycle ahead of the write
                  wdata_q    <= {DATA_WIDTH{MARCH_TABLE[0].ops[0].val}};
               end
            end
            ST_PRIME, ST_RUN: begin
               if (issue_en) begin
                  state_q    <= ST_RUN;
                  wr_q       <= ptr_op.wr;
                  addr_q     <= ptr_addr_q;
                  iss_rd_q   <= !ptr_op.wr;
                  iss_exp_q  <= {DATA_WIDTH{ptr_op.val}};
                  last_q     <= ptr_last;
                  ptr_elem_q <= ptr_elem_d;
                  ptr_addr_q <= ptr_addr_d;
                  ptr_opi_q  <= ptr_opi_d;
                  wdata_q    <= {DATA_WIDTH{nxt_val}};
               end else begin
                  state_q  <= ST_DRAIN;
                  wr_q     <= 1'b0;
                  iss_rd_q <= 1'b0;
                  drain_q  <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (drain_q) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  drain_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef MBIST_FAIL_LOG_EN
   elem_idx_t iss_elem_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        iss_elem_q <= '0;
      else if (issue_en) iss_elem_q <= ptr_elem_q;
   end
`endif

   assign mem.mem_write_read = wr_q;
   assign mem.mem_address    = addr_q;
   assign mem.mem_wdata      = wdata_q;
   assign busy               = busy_q;
   assign done               = done_q;

   mbist_rd_cmp #(
      .DATA_WIDTH     (DATA_WIDTH),
`ifdef MBIST_FAIL_LOG_EN
      .ADDR_WIDTH     (ADDR_WIDTH),
`endif
      .FAIL_CNT_WIDTH (FAIL_CNT_WIDTH)
   ) u_rd_cmp (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (start_acc),
      .push_i       (iss_rd_q),
      .exp_i        (iss_exp_q),
      .rdata_i      (mem.mem_rdata),
`ifdef MBIST_FAIL_LOG_EN
      .addr_i       (addr_q),
      .elem_i       (iss_elem_q),
      .fail_addr_o  (fail_addr),
      .fail_elem_o  (fail_elem),
      .fail_exp_o   (fail_exp),
      .fail_act_o   (fail_act),
`endif
      .fail_o       (fail),
      .fail_count_o (fail_count)
   );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl against a behavioural fault_mem model
// with injectable stuck-at faults; a second instance uses a 2-bit fail counter.
module tb_mbist_march_ctrl;
   import mbist_pkg::*;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int CAP = 15;
   localparam int FCW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic start2 = 1'b0;
   always #5 clk = ~clk;

   mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();
   mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif2 ();

   logic           busy, done, fail;
   logic [FCW-1:0] fail_count;
   logic           busy2, done2, fail2;
   logic [1:0]     fail_count2;
`ifdef MBIST_FAIL_LOG_EN
   logic [AW-1:0] fail_addr, fail_addr2;
   elem_idx_t     fail_elem, fail_elem2;
   logic [DW-1:0] fail_exp, fail_exp2, fail_act, fail_act2;
`endif

   mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .FAIL_CNT_WIDTH(FCW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mem(mif.master),
      .busy(busy), .done(done), .fail(fail), .fail_count(fail_count)
`ifdef MBIST_FAIL_LOG_EN
      , .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_exp(fail_exp), .fail_act(fail_act)
`endif
   );

   mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .FAIL_CNT_WIDTH(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start2), .mem(mif2.master),
      .busy(busy2), .done(done2), .fail(fail2), .fail_count(fail_count2)
`ifdef MBIST_FAIL_LOG_EN
      , .fail_addr(fail_addr2), .fail_elem(fail_elem2), .fail_exp(fail_exp2), .fail_act(fail_act2)
`endif
   );

   // Behavioural fault_mem: write data taken from the previous cycle, 2-cycle read latency
   logic [DW-1:0] mem [0:CAP];
   logic [DW-1:0] wd_prev = '0, rd_p1 = '0, rd_p2 = '0;
   logic          sa1_en = 1'b0, sa0_en = 1'b0;
   logic [AW-1:0] sa1_addr = '0, sa0_addr = '0;
   logic [DW-1:0] sa1_mask = '0, sa0_mask = '0;

   function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] v);
      logic [DW-1:0] r;
      r = v;
      if (sa1_en && a == sa1_addr) r = r | sa1_mask;
      if (sa0_en && a == sa0_addr) r = r & ~sa0_mask;
      return r;
   endfunction

   always @(posedge clk) begin
      wd_prev <= mif.mem_wdata;
      if (mif.mem_write_read) mem[mif.mem_address] <= wd_prev;
      rd_p1 <= faulty(mif.mem_address, mem[mif.mem_address]);
      rd_p2 <= rd_p1;
   end
   assign mif.mem_rdata = rd_p2;

   // Second memory: bit 0 stuck at 1 in every word
   logic [DW-1:0] mem2 [0:CAP];
   logic [DW-1:0] wd2_prev = '0, rd2_p1 = '0, rd2_p2 = '0;
   always @(posedge clk) begin
      wd2_prev <= mif2.mem_wdata;
      if (mif2.mem_write_read) mem2[mif2.mem_address] <= wd2_prev;
      rd2_p1 <= mem2[mif2.mem_address] | 8'h01;
      rd2_p2 <= rd2_p1;
   end
   assign mif2.mem_rdata = rd2_p2;

   int   n_vec = 0;
   int   n_fail = 0;
   logic op_wr [160];
   logic [AW-1:0] op_addr [160];
   int   busy_cycles;
   logic [FCW-1:0] cnt_at_done;
   logic timed_out;

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Called at the first negedge after start was sampled; counts busy cycles
   // and records the op on the bus for each RUN cycle
   task automatic run_test(input int pulse_at);
      busy_cycles = 0;
      timed_out = 1'b1;
      cnt_at_done = '0;
      for (int n = 0; n < 1000; n++) begin
         if (done) begin
            timed_out = 1'b0;
            cnt_at_done = fail_count;
            break;
         end
         if (busy) begin
            if (busy_cycles >= 1 && busy_cycles <= 160) begin
               op_wr[busy_cycles-1]   = mif.mem_write_read;
               op_addr[busy_cycles-1] = mif.mem_address;
            end
            busy_cycles++;
         end
         start = (n == pulse_at);
         @(negedge clk);
      end
      start = 1'b0;
      n_vec++;
      if (timed_out !== 1'b0) begin
         n_fail++;
         $display("FAIL run_timeout: done never rose within 1000 cycles");
      end
   endtask

   task automatic check_run(input string name, input int exp_cnt, input logic exp_fail);
      n_vec++;
      if (busy_cycles !== 163) begin
         n_fail++; $display("FAIL %s busy_cycles: got %0d want 163", name, busy_cycles);
      end
      n_vec++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL %s done: got %b want 1", name, done);
      end
      n_vec++;
      if (fail !== exp_fail) begin
         n_fail++; $display("FAIL %s fail: got %b want %b", name, fail, exp_fail);
      end
      n_vec++;
      if (fail_count !== FCW'(exp_cnt)) begin
         n_fail++; $display("FAIL %s fail_count: got %0d want %0d", name, fail_count, exp_cnt);
      end
      $display("[%s] busy_cycles=%0d fail=%b fail_count=%0d", name, busy_cycles, fail, fail_count);
   endtask

   task automatic check_idle_outputs(input string name);
      n_vec++;
      if ({busy, done, fail, fail_count, mif.mem_write_read, mif.mem_address, mif.mem_wdata} !== '0) begin
         n_fail++;
         $display("FAIL %s outputs: got busy=%b done=%b fail=%b cnt=%0d wr=%b addr=%0d wdata=%h want all 0",
                  name, busy, done, fail, fail_count, mif.mem_write_read, mif.mem_address, mif.mem_wdata);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_during");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset_after");
      n_vec++;
      if ({busy2, done2, fail2, fail_count2} !== '0) begin
         n_fail++; $display("FAIL reset_sat: got busy=%b done=%b fail=%b cnt=%0d want 0", busy2, done2, fail2, fail_count2);
      end
   endtask

   task automatic test_fault_free();
      sa1_en = 1'b0; sa0_en = 1'b0;
      pulse_start();
      run_test(-1);
      check_run("fault_free", 0, 1'b0);
      for (int k = 0; k < 16; k++) begin
         n_vec++;
         if ({op_wr[k], op_addr[k]} !== {1'b1, AW'(k)}) begin
            n_fail++; $display("FAIL e0_op%0d: got wr=%b addr=%0d want wr=1 addr=%0d", k, op_wr[k], op_addr[k], k);
         end
      end
      for (int k = 80; k < 112; k++) begin
         n_vec++;
         if ({op_wr[k], op_addr[k]} !== {1'((k - 80) % 2), AW'(15 - (k - 80) / 2)}) begin
            n_fail++; $display("FAIL e3_op%0d: got wr=%b addr=%0d want wr=%0d addr=%0d",
                               k, op_wr[k], op_addr[k], (k - 80) % 2, 15 - (k - 80) / 2);
         end
      end
      for (int k = 144; k < 160; k++) begin
         n_vec++;
         if ({op_wr[k], op_addr[k]} !== {1'b0, AW'(k - 144)}) begin
            n_fail++; $display("FAIL e5_op%0d: got wr=%b addr=%0d want wr=0 addr=%0d", k, op_wr[k], op_addr[k], k - 144);
         end
      end
   endtask

   task automatic test_stuck_at_1();
      sa1_en = 1'b1; sa1_addr = 4'd3; sa1_mask = 8'h01;
      pulse_start();
      run_test(-1);
      check_run("sa1_addr3_bit0", 3, 1'b1);
`ifdef MBIST_FAIL_LOG_EN
      n_vec++;
      if ({fail_addr, fail_elem, fail_exp, fail_act} !== {4'd3, 3'd1, 8'h00, 8'h01}) begin
         n_fail++; $display("FAIL sa1_log: got addr=%0d elem=%0d exp=%h act=%h want 3 1 00 01",
                            fail_addr, fail_elem, fail_exp, fail_act);
      end
`endif
      sa1_en = 1'b0;
   endtask

   task automatic test_stuck_at_0();
      sa0_en = 1'b1; sa0_addr = 4'd15; sa0_mask = 8'h80;
      pulse_start();
      run_test(-1);
      check_run("sa0_addr15_bit7", 2, 1'b1);
`ifdef MBIST_FAIL_LOG_EN
      n_vec++;
      if ({fail_addr, fail_elem, fail_exp, fail_act} !== {4'd15, 3'd2, 8'hFF, 8'h7F}) begin
         n_fail++; $display("FAIL sa0_log: got addr=%0d elem=%0d exp=%h act=%h want 15 2 ff 7f",
                            fail_addr, fail_elem, fail_exp, fail_act);
      end
`endif
      sa0_en = 1'b0;
   endtask

   // Final E5 read miscompares in the last DRAIN cycle; it must already be counted when done rises
   task automatic test_last_read_fault();
      sa1_en = 1'b1; sa1_addr = 4'd15; sa1_mask = 8'h01;
      pulse_start();
      run_test(-1);
      check_run("sa1_addr15_last", 3, 1'b1);
      n_vec++;
      if (cnt_at_done !== 8'd3) begin
         n_fail++; $display("FAIL count_at_done: got %0d want 3", cnt_at_done);
      end
      sa1_en = 1'b0;
   endtask

   task automatic test_abort();
      sa1_en = 1'b1; sa1_addr = 4'd3; sa1_mask = 8'h01;
      pulse_start();
      repeat (51) @(negedge clk);
      n_vec++;
      if ({busy, fail} !== 2'b11) begin
         n_fail++; $display("FAIL abort_pre: got busy=%b fail=%b want 1 1", busy, fail);
      end
      rst_n = 1'b0;
      #1;
      check_idle_outputs("abort_async");
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("abort_idle");
      $display("[abort] reset applied 50 cycles into RUN");
      pulse_start();
      run_test(-1);
      check_run("abort_rerun", 3, 1'b1);
      sa1_en = 1'b0;
   endtask

   task automatic test_start_during_run();
      sa1_en = 1'b1; sa1_addr = 4'd3; sa1_mask = 8'h01;
      pulse_start();
      run_test(40);
      check_run("start_in_run", 3, 1'b1);
      n_vec++;
      if ({op_wr[47], op_addr[47], op_wr[48], op_addr[48]} !== {1'b1, 4'd15, 1'b0, 4'd0}) begin
         n_fail++; $display("FAIL start_in_run_seq: got op47=%b/%0d op48=%b/%0d want 1/15 0/0",
                            op_wr[47], op_addr[47], op_wr[48], op_addr[48]);
      end
      sa1_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      pulse_start();
      n_vec++;
      if ({done, busy, fail, fail_count} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
         n_fail++; $display("FAIL restart_from_done: got done=%b busy=%b fail=%b cnt=%0d want 0 1 0 0",
                            done, busy, fail, fail_count);
      end
      run_test(-1);
      check_run("back_to_back", 0, 1'b0);
   endtask

   task automatic test_saturate();
      logic [1:0] prev;
      logic wrapped, to;
      prev = '0; wrapped = 1'b0; to = 1'b1;
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         if (fail_count2 < prev) wrapped = 1'b1;
         prev = fail_count2;
         if (done2) begin to = 1'b0; break; end
         @(negedge clk);
      end
      n_vec++;
      if (to !== 1'b0) begin
         n_fail++; $display("FAIL sat_timeout: done never rose within 1000 cycles");
      end
      n_vec++;
      if (wrapped !== 1'b0) begin
         n_fail++; $display("FAIL sat_wrap: counter decreased during run (got wrap=1 want 0)");
      end
      n_vec++;
      if ({fail2, fail_count2} !== 3'b111) begin
         n_fail++; $display("FAIL sat_count: got fail=%b cnt=%0d want 1 3", fail2, fail_count2);
      end
      $display("[saturate] fail=%b fail_count=%0d", fail2, fail_count2);
   endtask

   initial begin
      test_reset();
      test_fault_free();
      test_stuck_at_1();
      test_stuck_at_0();
      test_last_read_fault();
      test_abort();
      test_start_during_run();
      test_back_to_back();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
